draw_cat: RTL and testbench

DRAW_CAT -- requirements
Module: draw_cat

---
 rtl/cat_pkg.sv | 19 +
 rtl/timing_delay.sv | 39 +++
 rtl/draw_cat.sv | 149 ++++++++++++++
 tb/tb_draw_cat.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cat_pkg.sv
// Shared constants and the video timing bundle for the cat sprite overlay.
// Optional feature macro CAT_TRANSPARENCY_EN is consumed by draw_cat.
package cat_pkg;

    localparam int          CAT_X_SIZE = 64;
    localparam int          CAT_Y_SIZE = 64;
    localparam logic [11:0] KEY_COLOR  = 12'hF0F;
    localparam int          PIPE_LAT   = 3;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } timing_t;

endpackage

// File: rtl/timing_delay.sv
// N-stage delay line for the timing bundle plus a 12-bit side channel.
// All stages clear asynchronously on reset.
module timing_delay
    import cat_pkg::*;
#(
    parameter int N = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  timing_t     t_in,
    input  logic [11:0] side_in,
    output timing_t     t_out,
    output logic [11:0] side_out
);

    timing_t     t_q [N];
    logic [11:0] s_q [N];

    // shift the bundle and side channel one stage per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                t_q[i] <= '0;
                s_q[i] <= '0;
            end
        end else begin
            t_q[0] <= t_in;
            s_q[0] <= side_in;
            for (int i = 1; i < N; i++) begin
                t_q[i] <= t_q[i-1];
                s_q[i] <= s_q[i-1];
            end
        end
    end

    assign t_out    = t_q[N-1];
    assign side_out = s_q[N-1];

endmodule

// File: rtl/draw_cat.sv
// Cat sprite overlay: 3-stage pipeline compositing a ROM sprite on video.
// Define CAT_TRANSPARENCY_EN to treat KEY_COLOR sprite pixels as see-through.
module draw_cat
    import cat_pkg::timing_t;
    import cat_pkg::PIPE_LAT;
#(
    parameter int          CAT_X_SIZE = cat_pkg::CAT_X_SIZE,
    parameter int          CAT_Y_SIZE = cat_pkg::CAT_Y_SIZE,
    parameter logic [11:0] KEY_COLOR  = cat_pkg::KEY_COLOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] rgb_pixel,
    output logic [11:0] pixel_addr,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

`ifdef CAT_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    logic [11:0] x_lat;
    logic [11:0] y_lat;
    logic        vblnk_d;
    logic        in_cat1;
    logic        in_cat2;

    timing_t     t_in;
    timing_t     t2;
    logic [11:0] rgb2;

    logic [12:0] hc13;
    logic [12:0] vc13;
    logic [12:0] x13;
    logic [12:0] y13;
    logic        in_cat;
    logic [5:0]  addrx;
    logic [5:0]  addry;
    logic        is_key;
    logic [11:0] rgb_next;

    assign t_in = '{
        hcount: hcount_in,
        vcount: vcount_in,
        hsync:  hsync_in,
        vsync:  vsync_in,
        hblnk:  hblnk_in,
        vblnk:  vblnk_in
    };

    // widened compares keep positions near 4095 from wrapping into view
    assign hc13   = {2'b00, hcount_in};
    assign vc13   = {2'b00, vcount_in};
    assign x13    = {1'b0, x_lat};
    assign y13    = {1'b0, y_lat};
    assign in_cat = (hc13 >= x13) && (hc13 < x13 + 13'(CAT_X_SIZE))
                 && (vc13 >= y13) && (vc13 < y13 + 13'(CAT_Y_SIZE));
    assign addrx  = hcount_in[5:0] - x_lat[5:0];
    assign addry  = vcount_in[5:0] - y_lat[5:0];

    // position is sampled once per frame at the start of vertical blanking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_d <= 1'b0;
            x_lat   <= '0;
            y_lat   <= '0;
        end else begin
            vblnk_d <= vblnk_in;
            if (vblnk_in && !vblnk_d) begin
                x_lat <= xpos;
                y_lat <= ypos;
            end
        end
    end

    // stage 1 address and hit flag, stage 2 hit flag aligned with rom data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr <= '0;
            in_cat1    <= 1'b0;
            in_cat2    <= 1'b0;
        end else begin
            pixel_addr <= {addry, addrx};
            in_cat1    <= in_cat;
            in_cat2    <= in_cat1;
        end
    end

    timing_delay #(
        .N(PIPE_LAT - 1)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .t_in     (t_in),
        .side_in  (rgb_in),
        .t_out    (t2),
        .side_out (rgb2)
    );

    assign is_key = TRANSP_EN && (rgb_pixel == KEY_COLOR);

    // blanking wins, then an opaque sprite pixel, else the background
    always_comb begin
        rgb_next = rgb2;
        if (t2.hblnk || t2.vblnk)
            rgb_next = 12'h000;
        else if (in_cat2 && !is_key)
            rgb_next = rgb_pixel;
    end

    // stage 3 output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= t2.hcount;
            vcount_out <= t2.vcount;
            hsync_out  <= t2.hsync;
            vsync_out  <= t2.vsync;
            hblnk_out  <= t2.hblnk;
            vblnk_out  <= t2.vblnk;
            rgb_out    <= rgb_next;
        end
    end

endmodule

// File: tb/tb_draw_cat.sv
// Directed bench for draw_cat with a registered sprite ROM model
// whose word at address a is a ^ 12'h5A5.
module tb_draw_cat;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] xpos, ypos;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [11:0] rgb_pixel;
    logic [11:0] pixel_addr;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        force_key;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    draw_cat dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .xpos       (xpos),
        .ypos       (ypos),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .rgb_pixel  (rgb_pixel),
        .pixel_addr (pixel_addr),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    // sprite ROM with one-cycle registered read
    always @(posedge clk)
        rgb_pixel <= force_key ? 12'hF0F : (pixel_addr ^ 12'h5A5);

    task automatic chk(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        hcount_in = 11'd1000;
        vcount_in = 11'd1000;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b0;
        rgb_in    = 12'h777;
    endtask

    // one pixel in, idle behind it; check address at k+1, outputs at k+3
    task automatic pix(input string tag, input logic [10:0] h,
                       input logic [10:0] v, input logic [11:0] bg,
                       input logic hb, input logic [11:0] exp_addr,
                       input logic [11:0] exp_rgb);
        @(negedge clk);
        hcount_in = h;
        vcount_in = v;
        hsync_in  = h[0];
        vsync_in  = v[0];
        hblnk_in  = hb;
        vblnk_in  = 1'b0;
        rgb_in    = bg;
        @(posedge clk);
        #1;
        chk({tag, ".addr"}, pixel_addr, exp_addr);
        @(negedge clk);
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk({tag, ".rgb"}, rgb_out, exp_rgb);
        chk({tag, ".hcnt"}, {1'b0, hcount_out}, {1'b0, h});
        chk({tag, ".vcnt"}, {1'b0, vcount_out}, {1'b0, v});
        chk({tag, ".flags"}, {8'd0, hsync_out, vsync_out, hblnk_out,
            vblnk_out}, {8'd0, h[0], v[0], hb, 1'b0});
    endtask

    task automatic latch(input logic [11:0] x, input logic [11:0] y);
        @(negedge clk);
        xpos     = x;
        ypos     = y;
        vblnk_in = 1'b1;
        repeat (3) @(negedge clk);
        vblnk_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [11:0] exp_t;
        rst_n     = 1'b0;
        force_key = 1'b0;
        xpos      = 12'd0;
        ypos      = 12'd0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.rgb", rgb_out, 12'h000);
        chk("rst.addr", pixel_addr, 12'h000);
        chk("rst.hcnt", {1'b0, hcount_out}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        // first frame draws at (0,0) before any vblank capture
        pix("origin", 11'd0, 11'd0, 12'h123, 1'b0, 12'h000, 12'h5A5);

        latch(12'd30, 12'd40);
        pix("topleft", 11'd30, 11'd40, 12'h111, 1'b0, 12'h000, 12'h5A5);
        pix("botright", 11'd93, 11'd103, 12'h222, 1'b0, 12'hFFF, 12'hA5A);
        pix("left_out", 11'd29, 11'd40, 12'h333, 1'b0, 12'h03F, 12'h333);
        pix("right_in", 11'd93, 11'd40, 12'h444, 1'b0, 12'h03F, 12'h59A);
        pix("right_out", 11'd94, 11'd40, 12'h555, 1'b0, 12'h000, 12'h555);
        pix("below_out", 11'd40, 11'd104, 12'h666, 1'b0, 12'h00A, 12'h666);
        pix("hblank", 11'd40, 11'd50, 12'h888, 1'b1, 12'h28A, 12'h000);

`ifdef CAT_TRANSPARENCY_EN
        exp_t = 12'h999;
`else
        exp_t = 12'hF0F;
`endif
        force_key = 1'b1;
        pix("keycolor", 11'd40, 11'd50, 12'h999, 1'b0, 12'h28A, exp_t);
        force_key = 1'b0;

        // position change mid-frame only takes effect after vblank
        @(negedge clk);
        xpos = 12'd200;
        pix("old_x_in", 11'd30, 11'd100, 12'h0AA, 1'b0, 12'hF00, 12'hAA5);
        pix("old_x_out", 11'd200, 11'd100, 12'h0BB, 1'b0, 12'hF2A, 12'h0BB);
        latch(12'd200, 12'd40);
        pix("new_x_in", 11'd200, 11'd100, 12'h0CC, 1'b0, 12'hF00, 12'hAA5);
        pix("new_x_out", 11'd30, 11'd100, 12'h0DD, 1'b0, 12'hF16, 12'h0DD);

        // reset during active video clears outputs without a clock edge
        @(negedge clk);
        hcount_in = 11'd210;
        vcount_in = 11'd50;
        rgb_in    = 12'hEEE;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst.rgb", rgb_out, 12'h5A5 ^ 12'h28A);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.rgb", rgb_out, 12'h000);
        chk("mid_rst.addr", pixel_addr, 12'h000);
        chk("mid_rst.hcnt", {1'b0, hcount_out}, 12'h000);
        chk("mid_rst.vcnt", {1'b0, vcount_out}, 12'h000);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // latched position returns to (0,0) after reset
        pix("post_rst", 11'd5, 11'd3, 12'h345, 1'b0, 12'h0C5, 12'h0C5 ^ 12'h5A5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
